// File: rtl/pe_no_fifo_pkg.sv
// -----------------------------------------------------------------------------
// pe_no_fifo_pkg
//   Shared definitions for the multiply-accumulate processing element.
//   - PE_ACC_LATENCY : rising edges from sampling a beat to its effect on c.
//   - pe_flags_t     : per-beat control bundle that travels alongside the data
//                      through the pipeline {vld, start, last}.
// -----------------------------------------------------------------------------
package pe_no_fifo_pkg;

  localparam int PE_ACC_LATENCY = 3;

  typedef struct packed {
    logic vld;
    logic start;
    logic last;
  } pe_flags_t;

endpackage : pe_no_fifo_pkg

// File: rtl/pe_mac_stage.sv
// -----------------------------------------------------------------------------
// pe_mac_stage
//   Final (accumulate) stage of the processing element. Loads or accumulates the
//   incoming product on valid beats and tracks whether the accumulator currently
//   holds a completed dot product.
// Ports
//   clk            in  clock, rising edge
//   clr_n          in  synchronous active-low reset
//   i_flg          in  stage flags {vld, start, last} for the product on i_prod
//   i_prod         in  product, already sized to ACC_WIDTH
//   o_acc          out accumulator register (wraps modulo 2**ACC_WIDTH)
//   o_output_valid out accumulator holds a completed sum
// -----------------------------------------------------------------------------
module pe_mac_stage
  import pe_no_fifo_pkg::*;
#(
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  pe_flags_t            i_flg,
  input  logic [ACC_WIDTH-1:0] i_prod,
  output logic [ACC_WIDTH-1:0] o_acc,
  output logic                 o_output_valid
);

  logic [ACC_WIDTH-1:0] r_acc_p2;
  logic                 r_vld_p2;

  // Unsigned sum that simply drops the carry out.
  function automatic logic [ACC_WIDTH-1:0] acc_wrap_add(
    input logic [ACC_WIDTH-1:0] x,
    input logic [ACC_WIDTH-1:0] y
  );
    return x + y;
  endfunction

  // ---- stage 3: accumulate ----
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_acc_p2 <= '0;
      r_vld_p2 <= 1'b0;
    end else if (i_flg.vld) begin
      r_acc_p2 <= i_flg.start ? i_prod : acc_wrap_add(r_acc_p2, i_prod);
      // last wins over start so a single-beat sequence completes immediately.
      if (i_flg.last) begin
        r_vld_p2 <= 1'b1;
      end else if (i_flg.start) begin
        r_vld_p2 <= 1'b0;
      end
    end
  end

  assign o_acc          = r_acc_p2;
  assign o_output_valid = r_vld_p2;

endmodule : pe_mac_stage

// File: rtl/pe_no_fifo.sv
// -----------------------------------------------------------------------------
// pe_no_fifo
//   Unsigned multiply-accumulate processing element. Computes the dot product
//   of the a/b beats between start and last through a three-stage pipeline:
//   input register, multiply register, accumulate register. One operand pair
//   is accepted on every valid_in cycle; there is no buffering or backpressure.
// Ports
//   clk           in  clock, rising edge
//   clr_n         in  synchronous active-low reset (clears every stage)
//   start         in  first beat of a sequence (qualified by valid_in)
//   valid_in      in  a/b/start/last valid this cycle
//   last          in  final beat of a sequence (qualified by valid_in)
//   a, b          in  unsigned operands, DATA_WIDTH bits
//   c             out accumulator value, ACC_WIDTH bits
//   output_valid  out c holds a completed sum
// -----------------------------------------------------------------------------
module pe_no_fifo
  import pe_no_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = DATA_WIDTH ** 2
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  start,
  input  logic                  valid_in,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  c,
  output logic                  output_valid
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int MUL_W  = (ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W;

  // Full product computed wide enough for both operands and the accumulator,
  // then zero-extended or truncated to the accumulator width.
  function automatic logic [ACC_WIDTH-1:0] mul_fit(
    input logic [DATA_WIDTH-1:0] x,
    input logic [DATA_WIDTH-1:0] y
  );
    logic [MUL_W-1:0] full;
    full = MUL_W'(x) * MUL_W'(y);
    return full[ACC_WIDTH-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] r_a_p0;
  logic [DATA_WIDTH-1:0] r_b_p0;
  pe_flags_t             r_flg_p0;
  logic [ACC_WIDTH-1:0]  r_p_p1;
  pe_flags_t             r_flg_p1;
  logic [ACC_WIDTH-1:0]  w_acc;
  logic                  w_output_valid;

  // ---- stage 1: input register ----
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_a_p0   <= '0;
      r_b_p0   <= '0;
      r_flg_p0 <= '0;
    end else begin
      r_a_p0         <= a;
      r_b_p0         <= b;
      r_flg_p0.vld   <= valid_in;
      r_flg_p0.start <= start & valid_in;
      r_flg_p0.last  <= last & valid_in;
    end
  end

  // ---- stage 2: multiply register ----
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_p_p1   <= '0;
      r_flg_p1 <= '0;
    end else begin
      r_p_p1   <= mul_fit(r_a_p0, r_b_p0);
      r_flg_p1 <= r_flg_p0;
    end
  end

  // ---- stage 3: accumulate ----
  pe_mac_stage #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk            (clk),
    .clr_n          (clr_n),
    .i_flg          (r_flg_p1),
    .i_prod         (r_p_p1),
    .o_acc          (w_acc),
    .o_output_valid (w_output_valid)
  );

  assign c            = w_acc;
  assign output_valid = w_output_valid;

endmodule : pe_no_fifo

// File: tb/tb_pe_no_fifo.sv
module tb_pe_no_fifo;
  import pe_no_fifo_pkg::*;

  localparam int DW = 4;
  localparam int AW = DW ** 2;

  logic          clk = 1'b0;
  logic          clr_n;
  logic          start;
  logic          valid_in;
  logic          last;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [AW-1:0] c;
  logic          output_valid;

  int n_assert = 0;
  int n_fail   = 0;

  pe_no_fifo #(
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (AW)
  ) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .start        (start),
    .valid_in     (valid_in),
    .last         (last),
    .a            (a),
    .b            (b),
    .c            (c),
    .output_valid (output_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge so the next rising edge samples them cleanly.
  task automatic drive(input logic v, input logic s, input logic l,
                       input logic [DW-1:0] av, input logic [DW-1:0] bv);
    @(negedge clk);
    valid_in = v;
    start    = s;
    last     = l;
    a        = av;
    b        = bv;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Called right after the last beat was driven: its sampling edge is passed by
  // idle(), then the remaining edges, then sample 1 time unit after the edge.
  task automatic finish_seq();
    idle();
    repeat (PE_ACC_LATENCY - 1) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n    = 1'b0;
    valid_in = 1'b0;
    start    = 1'b0;
    last     = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic seq_const(input int n, input logic [DW-1:0] av, input logic [DW-1:0] bv);
    for (int i = 0; i < n; i++) drive(1'b1, i == 0, i == n - 1, av, bv);
    finish_seq();
  endtask

  logic [AW-1:0] exp_sum;
  logic [DW-1:0] ra;
  logic [DW-1:0] rb;

  initial begin
    clr_n = 1'b0; start = 1'b0; valid_in = 1'b0; last = 1'b0; a = '0; b = '0;

    // Reset state
    @(posedge clk); #1;
    chk("reset_c", c, 16'h0000);
    chk("reset_ov", {15'd0, output_valid}, 16'h0000);
    @(negedge clk); clr_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("idle_c", c, 16'h0000);
    chk("idle_ov", {15'd0, output_valid}, 16'h0000);

    // 16 x (1*1)
    seq_const(16, 4'd1, 4'd1);
    chk("ones_c", c, 16'h0010);
    chk("ones_ov", {15'd0, output_valid}, 16'h0001);
    repeat (6) @(posedge clk); #1;
    chk("ones_hold_c", c, 16'h0010);
    chk("ones_hold_ov", {15'd0, output_valid}, 16'h0001);

    // 16 x (15*15) = 3600
    seq_const(16, 4'hF, 4'hF);
    chk("max_c", c, 16'h0E10);
    chk("max_ov", {15'd0, output_valid}, 16'h0001);

    // Random sequences, reset in between
    for (int s = 0; s < 10; s++) begin
      do_reset();
      exp_sum = '0;
      for (int i = 0; i < 5; i++) begin
        ra = DW'($urandom_range(0, 15));
        rb = DW'($urandom_range(0, 15));
        exp_sum = exp_sum + AW'(ra) * AW'(rb);
        drive(1'b1, i == 0, i == 4, ra, rb);
      end
      finish_seq();
      chk($sformatf("rand%0d_c", s), c, exp_sum);
      chk($sformatf("rand%0d_ov", s), {15'd0, output_valid}, 16'h0001);
    end

    // Single beat start=last
    seq_const(1, 4'd3, 4'd5);
    chk("single_c", c, 16'd15);
    chk("single_ov", {15'd0, output_valid}, 16'h0001);

    // Back-to-back: A = 4 x (2*3), B = 2 x (1*1) starting right after A's last
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, i == 3, 4'd2, 4'd3);
    drive(1'b1, 1'b1, 1'b0, 4'd1, 4'd1);
    drive(1'b1, 1'b0, 1'b1, 4'd1, 4'd1);
    @(posedge clk); #1;
    chk("b2b_a_c", c, 16'd24);
    chk("b2b_a_ov", {15'd0, output_valid}, 16'h0001);
    idle();
    @(posedge clk); #1;
    chk("b2b_bstart_c", c, 16'd1);
    chk("b2b_bstart_ov", {15'd0, output_valid}, 16'h0000);
    @(posedge clk); #1;
    chk("b2b_b_c", c, 16'd2);
    chk("b2b_b_ov", {15'd0, output_valid}, 16'h0001);

    // Bubbles inside a 4-beat 2*2 sequence
    drive(1'b1, 1'b1, 1'b0, 4'd2, 4'd2);
    drive(1'b0, 1'b1, 1'b1, 4'd9, 4'd9);
    drive(1'b1, 1'b0, 1'b0, 4'd2, 4'd2);
    idle();
    idle();
    drive(1'b1, 1'b0, 1'b0, 4'd2, 4'd2);
    drive(1'b1, 1'b0, 1'b1, 4'd2, 4'd2);
    finish_seq();
    chk("bubble_c", c, 16'd16);
    chk("bubble_ov", {15'd0, output_valid}, 16'h0001);

    // Reset mid-sequence: the last beat coincides with reset and must be dropped
    drive(1'b1, 1'b1, 1'b0, 4'd3, 4'd3);
    drive(1'b1, 1'b0, 1'b0, 4'd3, 4'd3);
    @(negedge clk);
    clr_n = 1'b0; valid_in = 1'b1; last = 1'b1; start = 1'b0; a = 4'd3; b = 4'd3;
    @(posedge clk); #1;
    chk("midrst_c", c, 16'h0000);
    chk("midrst_ov", {15'd0, output_valid}, 16'h0000);
    @(negedge clk);
    clr_n = 1'b1; valid_in = 1'b0; last = 1'b0; a = '0; b = '0;
    repeat (5) @(posedge clk); #1;
    chk("postrst_c", c, 16'h0000);
    chk("postrst_ov", {15'd0, output_valid}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_pe_no_fifo
